uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
- Parametrised UART boot loader that fills the instruction memory before the core leaves reset.
- Receives 8N1 serial bytes on rx and assembles them little-endian into WORD_BYTES-wide words.
- Issues one memory write per word and raises load_done when the image is complete.
- Generalises the fixed 256-byte / 9600-baud loader: configurable baud, word width and depth, an optional length-header mode, framing-error detection, and re-arm for reloading.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be >= 4.
- WORD_BYTES, 4, bytes per memory word; word width DW = 8*WORD_BYTES.
- DEPTH, 64, number of memory words; ADDR_W = $clog2(DEPTH).
- HEADER_EN, 0, when 1, a 16-bit little-endian word-count header precedes the payload.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART serial input, idle high.
- start  in  1  one-cycle pulse that re-arms the loader after load_done.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  word address for mem_we.
- mem_wdata  out  DW  assembled word; byte 0 received occupies [7:0].
- busy  out  1  high from the first start bit until load_done.
- load_done  out  1  high when the image is complete; releases the core.
- frame_err  out  1  sticky flag: at least one stop bit was sampled low.
- word_count  out  ADDR_W+1  number of words written since the last arm.

Behaviour:
- Reset (rst=1 on a clock edge): every output is 0; both FSMs return to their first state; synchroniser flops are forced to 1.
- rx passes through a 2-FF synchroniser. All sampling below uses the synchronised signal rx_s.
- RX FSM states:
  - IDLE: a falling rx_s moves to START and clears the bit counter.
  - START: wait CLKS_PER_BIT/2 clocks, then sample. rx_s=0 goes to DATA; rx_s=1 is a glitch and returns to IDLE with no byte.
  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
  - STOP: after CLKS_PER_BIT clocks, sample. rx_s=1 raises byte_valid for exactly 1 cycle; rx_s=0 sets frame_err, discards the byte, then returns to IDLE.
- Loader FSM states: HDR_LO, HDR_HI (present only when HEADER_EN=1), WORDS, DONE.
- Header mode (HEADER_EN=1):
  - The first byte is the count low byte, the second the high byte.
  - target = min(count, DEPTH).
  - target=0 goes directly to DONE, with no writes.
- No-header mode (HEADER_EN=0): target = DEPTH, and the FSM starts in WORDS.
- WORDS:
  - Each byte_valid shifts into the byte lane given by the byte index 0..WORD_BYTES-1.
  - On the last lane, mem_we is asserted the cycle after byte_valid, with mem_addr = word_count and the full word on mem_wdata.
  - word_count increments in the same cycle as mem_we.
  - When word_count reaches target, move to DONE in the cycle after the final mem_we.
- DONE:
  - load_done=1 and busy=0.
  - Further received bytes are ignored: no mem_we, and frame_err is not updated.
- start:
  - Honoured only in DONE. It clears word_count, the byte index, load_done and frame_err, and returns to HDR_LO or WORDS on the next cycle.
  - start outside DONE is ignored.
- frame_err does not abort the load. The discarded byte is not counted, so the byte alignment of the remaining data shifts.
- mem_addr and mem_wdata hold their last value between strobes.
- A byte_valid and a start pulse in the same cycle cannot conflict, because bytes are ignored in DONE.
- Reset mid-frame:
  - The partial byte and partial word are lost; no mem_we occurs.
  - After reset, rx must be high for one full frame before the next valid start bit.
- Latency: from the final stop-bit sample to mem_we is 1 clock; from the last mem_we to load_done is 1 clock.

Test Plan:
- Bench config for all scenarios: CLK_FREQ=1000000, BAUD=100000 (10 clk/bit), WORD_BYTES=4, DEPTH=8.
- No header: send bytes 93 02 A0 00, then 33 03 53 00 ... for 8 words. Expect mem_we at addr 0 with 00A00293, at addr 1 with 00530333, then load_done=1 one cycle after the write at addr 7 and word_count=8.
- HEADER_EN=1, header 02 00 followed by 8 payload bytes: expect exactly 2 writes, load_done=1, and no mem_we for any extra byte sent afterwards.
- Header with count FF 00: expect target clamped to 8 and exactly 8 writes. Header 00 00: expect load_done=1 with no mem_we.
- Framing error: send a byte with its stop bit low: expect frame_err=1 and word_count unchanged. Then pulse start in DONE: expect frame_err=0, load_done=0, and a second full load writing from addr 0.
- Glitch: rx low for 3 clocks only: expect no byte. Then assert rst in the middle of the 2nd byte: all outputs go to 0, and a fresh 4-byte word afterwards writes addr 0 correctly.

Source files
------------

// File: rtl/uart_imem_loader.sv
`timescale 1ns/1ps
// uart_imem_loader: 8N1 UART receiver feeding a little-endian word assembler that
// writes an instruction-memory image and releases the core once the image is complete.
module uart_imem_loader #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 64,
  parameter int HEADER_EN  = 0,
  localparam int DW        = 8 * WORD_BYTES,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              frame_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [CNT_W-1:0]  HALF_C   = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_C   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_HDR_LO, LD_HDR_HI, LD_WORDS, LD_DONE} ld_state_t;

  localparam ld_state_t LD_FIRST = (HEADER_EN != 0) ? LD_HDR_LO : LD_WORDS;

  logic              sync1_r, rx_s, rx_d_r;
  logic              rx_fall_s;
  rx_state_t         rx_state_r, rx_next_s;
  logic [CNT_W-1:0]  clk_cnt_r;
  logic [2:0]        bit_cnt_r;
  logic [7:0]        shift_r;
  logic              sample_s, start_ok_s, byte_valid_s, stop_err_s;

  ld_state_t         ld_state_r, ld_next_s;
  logic              lane_write_s, word_write_s, hdr_lo_s, hdr_hi_s, rearm_s;
  logic [IDX_W-1:0]  byte_idx_r;
  logic [DW-1:0]     word_buf_r, assembled_s;
  logic [7:0]        hdr_lo_r;
  logic [15:0]       hdr_count_s;
  logic [ADDR_W:0]   hdr_target_s, target_r, word_count_r;
  logic              mem_we_r, busy_r, load_done_r, frame_err_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DW-1:0]     mem_wdata_r;

  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = busy_r;
  assign load_done  = load_done_r;
  assign frame_err  = frame_err_r;
  assign word_count = word_count_r;

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
      rx_d_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
      rx_d_r  <= rx_s;
    end
  end

  assign rx_fall_s = rx_d_r & ~rx_s;

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) rx_state_r <= RX_IDLE;
    else     rx_state_r <= rx_next_s;
  end

  // Receiver next state and sampling strobes.
  always_comb begin
    rx_next_s    = rx_state_r;
    sample_s     = 1'b0;
    start_ok_s   = 1'b0;
    byte_valid_s = 1'b0;
    stop_err_s   = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_fall_s) rx_next_s = RX_START;
        else           rx_next_s = RX_IDLE;
      end
      RX_START: begin
        if (clk_cnt_r == HALF_C) begin
          if (rx_s) begin
            rx_next_s = RX_IDLE;
          end else begin
            rx_next_s  = RX_DATA;
            start_ok_s = 1'b1;
          end
        end else begin
          rx_next_s = RX_START;
        end
      end
      RX_DATA: begin
        if (clk_cnt_r == FULL_C) begin
          sample_s = 1'b1;
          if (bit_cnt_r == 3'd7) rx_next_s = RX_STOP;
          else                   rx_next_s = RX_DATA;
        end else begin
          rx_next_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (clk_cnt_r == FULL_C) begin
          rx_next_s = RX_IDLE;
          if (rx_s) byte_valid_s = 1'b1;
          else      stop_err_s   = 1'b1;
        end else begin
          rx_next_s = RX_STOP;
        end
      end
      default: rx_next_s = RX_IDLE;
    endcase
  end

  // Bit timing counter, bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_r <= '0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      if (rx_state_r == RX_IDLE || rx_next_s != rx_state_r || sample_s) clk_cnt_r <= '0;
      else clk_cnt_r <= clk_cnt_r + CNT_W'(1);
      if (rx_state_r == RX_IDLE && rx_fall_s) bit_cnt_r <= 3'd0;
      else if (sample_s)                       bit_cnt_r <= bit_cnt_r + 3'd1;
      if (sample_s) shift_r <= {rx_s, shift_r[7:1]};
    end
  end

  always_comb begin
    assembled_s = word_buf_r;
    assembled_s[{byte_idx_r, 3'b000} +: 8] = shift_r;
  end

  // Header count is clamped so an oversized image never runs past memory.
  assign hdr_count_s  = {shift_r, hdr_lo_r};
  assign hdr_target_s = (hdr_count_s > 16'(DEPTH)) ? DEPTH_C : hdr_count_s[ADDR_W:0];

  // Loader state register.
  always_ff @(posedge clk) begin
    if (rst) ld_state_r <= LD_FIRST;
    else     ld_state_r <= ld_next_s;
  end

  // Loader next state and byte-routing strobes.
  always_comb begin
    ld_next_s    = ld_state_r;
    lane_write_s = 1'b0;
    word_write_s = 1'b0;
    hdr_lo_s     = 1'b0;
    hdr_hi_s     = 1'b0;
    rearm_s      = 1'b0;
    case (ld_state_r)
      LD_HDR_LO: begin
        if (byte_valid_s) begin
          hdr_lo_s  = 1'b1;
          ld_next_s = LD_HDR_HI;
        end else begin
          ld_next_s = LD_HDR_LO;
        end
      end
      LD_HDR_HI: begin
        if (byte_valid_s) begin
          hdr_hi_s  = 1'b1;
          ld_next_s = (hdr_target_s == '0) ? LD_DONE : LD_WORDS;
        end else begin
          ld_next_s = LD_HDR_HI;
        end
      end
      LD_WORDS: begin
        if (word_count_r == target_r) begin
          ld_next_s = LD_DONE;
        end else if (byte_valid_s) begin
          lane_write_s = 1'b1;
          word_write_s = (byte_idx_r == LAST_IDX);
          ld_next_s    = LD_WORDS;
        end else begin
          ld_next_s = LD_WORDS;
        end
      end
      LD_DONE: begin
        if (start) begin
          rearm_s   = 1'b1;
          ld_next_s = LD_FIRST;
        end else begin
          ld_next_s = LD_DONE;
        end
      end
      default: ld_next_s = LD_FIRST;
    endcase
  end

  // Word assembly, memory write port and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_r   <= '0;
      word_buf_r   <= '0;
      hdr_lo_r     <= 8'h00;
      target_r     <= (HEADER_EN != 0) ? '0 : DEPTH_C;
      word_count_r <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      busy_r       <= 1'b0;
      load_done_r  <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      mem_we_r    <= 1'b0;
      load_done_r <= (ld_next_s == LD_DONE);
      if (rearm_s) begin
        byte_idx_r   <= '0;
        word_buf_r   <= '0;
        word_count_r <= '0;
        frame_err_r  <= 1'b0;
      end else begin
        if (stop_err_s && ld_state_r != LD_DONE) frame_err_r <= 1'b1;
        if (hdr_lo_s) hdr_lo_r <= shift_r;
        if (hdr_hi_s) target_r <= hdr_target_s;
        if (word_write_s) begin
          mem_we_r     <= 1'b1;
          mem_addr_r   <= word_count_r[ADDR_W-1:0];
          mem_wdata_r  <= assembled_s;
          word_count_r <= word_count_r + (ADDR_W + 1)'(1);
          byte_idx_r   <= '0;
        end else if (lane_write_s) begin
          word_buf_r <= assembled_s;
          byte_idx_r <= byte_idx_r + IDX_W'(1);
        end
      end
      // busy follows a confirmed start bit, so a line glitch does not raise it
      if (ld_next_s == LD_DONE)                 busy_r <= 1'b0;
      else if (start_ok_s)                      busy_r <= 1'b1;
      else if (rearm_s)                         busy_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
`timescale 1ns/1ps
// Bench for uart_imem_loader: one instance without and one with the length header,
// random images checked against a byte-list model of the expected memory writes.
module tb_uart_imem_loader;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rx0 = 1'b1, start0 = 1'b0;
  logic rst1 = 1'b1, rx1 = 1'b1, start1 = 1'b0;
  logic we0, we1, busy0, busy1, done0, done1, ferr0, ferr1;
  logic [2:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0] wc0, wc1;

  uart_imem_loader #(.CLK_FREQ(1000000), .BAUD(100000), .WORD_BYTES(4), .DEPTH(8), .HEADER_EN(0)) dut0 (
    .clk(clk), .rst(rst0), .rx(rx0), .start(start0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .busy(busy0), .load_done(done0), .frame_err(ferr0), .word_count(wc0));

  uart_imem_loader #(.CLK_FREQ(1000000), .BAUD(100000), .WORD_BYTES(4), .DEPTH(8), .HEADER_EN(1)) dut1 (
    .clk(clk), .rst(rst1), .rx(rx1), .start(start1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .busy(busy1), .load_done(done1), .frame_err(ferr1), .word_count(wc1));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int oa0[$], oa1[$], oc0[$], oc1[$];
  logic [31:0] od0[$], od1[$];
  int done_cyc0 = 0, done_cyc1 = 0;
  logic done_prev0 = 1'b0, done_prev1 = 1'b0;

  logic [7:0] mb[$];
  int exp_addr[$];
  logic [31:0] exp_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we0) begin oa0.push_back(int'(addr0)); od0.push_back(wdata0); oc0.push_back(cyc); end
    if (we1) begin oa1.push_back(int'(addr1)); od1.push_back(wdata1); oc1.push_back(cyc); end
    if (done0 && !done_prev0) done_cyc0 <= cyc;
    if (done1 && !done_prev1) done_cyc1 <= cyc;
    done_prev0 <= done0;
    done_prev1 <= done1;
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  // Expected writes: consecutive groups of 4 payload bytes, little-endian, up to the target.
  task automatic model_expect(input bit hdr);
    int target, base, n, p;
    exp_addr.delete();
    exp_data.delete();
    if (hdr) begin
      n = int'(mb[0]) + 256 * int'(mb[1]);
      target = (n > DEPTH) ? DEPTH : n;
      base = 2;
    end else begin
      target = DEPTH;
      base = 0;
    end
    for (int w = 0; w < target; w++) begin
      p = base + 4 * w;
      if (p + 3 < mb.size()) begin
        exp_addr.push_back(w);
        exp_data.push_back({mb[p + 3], mb[p + 2], mb[p + 1], mb[p]});
      end
    end
  endtask

  task automatic clear_obs(input int which);
    if (which == 0) begin oa0.delete(); od0.delete(); oc0.delete(); end
    else begin oa1.delete(); od1.delete(); oc1.delete(); end
  endtask

  task automatic check_writes(input int which, input string tag);
    int a[$];
    logic [31:0] d[$];
    int n;
    if (which == 0) begin a = oa0; d = od0; end
    else begin a = oa1; d = od1; end
    chk({tag, "_write_count"}, a.size(), exp_addr.size());
    n = (a.size() < exp_addr.size()) ? a.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_write_addr"}, a[i], exp_addr[i]);
      chk({tag, "_write_data"}, d[i], exp_data[i]);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input logic stop);
    @(negedge clk);
    set_rx(which, 1'b0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, b[i]);
      repeat (10) @(negedge clk);
    end
    set_rx(which, stop);
    repeat (10) @(negedge clk);
    set_rx(which, 1'b1);
    repeat (stop ? 3 : 12) @(negedge clk);
  endtask

  task automatic send_valid(input int which, input logic [7:0] b);
    mb.push_back(b);
    send_byte(which, b, 1'b1);
  endtask

  task automatic send_random(input int which, input int n);
    for (int i = 0; i < n; i++) send_valid(which, 8'($urandom));
  endtask

  task automatic wait_done(input int which, input string tag);
    for (int i = 0; i < 300; i++) begin
      if ((which == 0 && done0) || (which == 1 && done1)) break;
      @(negedge clk);
    end
    chk({tag, "_load_done"}, (which == 0) ? done0 : done1, 1'b1);
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (which == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic check_zero0(input string tag);
    chk({tag, "_mem_we"}, we0, 1'b0);
    chk({tag, "_mem_addr"}, addr0, 3'd0);
    chk({tag, "_mem_wdata"}, wdata0, 32'd0);
    chk({tag, "_busy"}, busy0, 1'b0);
    chk({tag, "_load_done"}, done0, 1'b0);
    chk({tag, "_frame_err"}, ferr0, 1'b0);
    chk({tag, "_word_count"}, wc0, 4'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state of the no-header instance
    repeat (3) @(negedge clk);
    check_zero0("reset0");
    rst0 = 1'b0;
    repeat (20) @(negedge clk);

    // Full no-header image, first two words fixed
    mb.delete();
    clear_obs(0);
    send_valid(0, 8'h93); send_valid(0, 8'h02); send_valid(0, 8'hA0); send_valid(0, 8'h00);
    chk("busy_mid_load", busy0, 1'b1);
    send_valid(0, 8'h33); send_valid(0, 8'h03); send_valid(0, 8'h53); send_valid(0, 8'h00);
    send_random(0, 24);
    wait_done(0, "img1");
    model_expect(1'b0);
    check_writes(0, "img1");
    if (od0.size() > 1) begin
      chk("img1_word0", od0[0], 32'h00A00293);
      chk("img1_word1", od0[1], 32'h00530333);
    end
    if (oc0.size() > 0) chk("img1_done_latency", done_cyc0, oc0[oc0.size() - 1] + 1);
    chk("img1_word_count", wc0, 4'd8);
    chk("img1_busy_done", busy0, 1'b0);
    clear_obs(0);
    send_byte(0, 8'($urandom), 1'b1);
    chk("img1_extra_no_write", oa0.size(), 0);
    chk("img1_extra_count", wc0, 4'd8);

    // Re-arm, then a framing error part way through the load
    pulse_start(0);
    chk("rearm_done_clear", done0, 1'b0);
    chk("rearm_count_clear", wc0, 4'd0);
    mb.delete();
    clear_obs(0);
    send_random(0, 2);
    send_byte(0, 8'($urandom), 1'b0);
    chk("ferr_set", ferr0, 1'b1);
    chk("ferr_count_unchanged", wc0, 4'd0);
    pulse_start(0);
    chk("start_ignored_count", wc0, 4'd0);
    chk("start_ignored_ferr", ferr0, 1'b1);
    send_random(0, 30);
    wait_done(0, "img2");
    model_expect(1'b0);
    check_writes(0, "img2");
    chk("img2_ferr_sticky", ferr0, 1'b1);
    pulse_start(0);
    chk("rearm2_ferr_clear", ferr0, 1'b0);
    chk("rearm2_done_clear", done0, 1'b0);
    mb.delete();
    clear_obs(0);
    send_random(0, 32);
    wait_done(0, "img3");
    model_expect(1'b0);
    check_writes(0, "img3");
    chk("img3_word_count", wc0, 4'd8);

    // Glitch on rx must not produce a byte
    pulse_start(0);
    mb.delete();
    clear_obs(0);
    @(negedge clk);
    rx0 = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy", busy0, 1'b0);
    send_random(0, 4);
    repeat (5) @(negedge clk);
    model_expect(1'b0);
    check_writes(0, "glitch");

    // Reset in the middle of the second byte of a word
    clear_obs(0);
    send_byte(0, 8'($urandom), 1'b1);
    rx0 = 1'b0;
    repeat (35) @(negedge clk);
    rst0 = 1'b1;
    repeat (2) @(negedge clk);
    check_zero0("midrst");
    rx0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    repeat (110) @(negedge clk);
    chk("midrst_no_write", oa0.size(), 0);
    mb.delete();
    send_random(0, 4);
    repeat (5) @(negedge clk);
    model_expect(1'b0);
    check_writes(0, "post_rst");
    chk("post_rst_count", wc0, 4'd1);

    // Header instance: count 2 with 8 payload bytes
    chk("reset1_done", done1, 1'b0);
    chk("reset1_count", wc1, 4'd0);
    rst1 = 1'b0;
    repeat (20) @(negedge clk);
    mb.delete();
    clear_obs(1);
    send_valid(1, 8'h02); send_valid(1, 8'h00);
    send_random(1, 8);
    wait_done(1, "hdr2");
    model_expect(1'b1);
    check_writes(1, "hdr2");
    chk("hdr2_word_count", wc1, 4'd2);
    clear_obs(1);
    send_byte(1, 8'($urandom), 1'b1);
    send_byte(1, 8'($urandom), 1'b1);
    chk("hdr2_extra_no_write", oa1.size(), 0);

    // Oversized header clamps to DEPTH
    pulse_start(1);
    mb.delete();
    clear_obs(1);
    send_valid(1, 8'hFF); send_valid(1, 8'h00);
    send_random(1, 32);
    wait_done(1, "hdrff");
    model_expect(1'b1);
    check_writes(1, "hdrff");
    chk("hdrff_word_count", wc1, 4'd8);
    if (oc1.size() > 0) chk("hdrff_done_latency", done_cyc1, oc1[oc1.size() - 1] + 1);

    // Zero-length header completes with no writes
    pulse_start(1);
    chk("hdr0_rearm", done1, 1'b0);
    mb.delete();
    clear_obs(1);
    send_valid(1, 8'h00); send_valid(1, 8'h00);
    wait_done(1, "hdr0");
    model_expect(1'b1);
    check_writes(1, "hdr0");
    chk("hdr0_word_count", wc1, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
